fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset (word address).
REQ-002 SHALL have parameter DEPTH, default 2, the instruction buffer entries; legal values are 2 or 4.
REQ-003 SHALL have parameter NOP, default 32'h0000_0000, the instruction word presented when no valid entry exists.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-006 SHALL have port stall, input, 1 bit, the decode-stage hold; while high, the head entry is not consumed.
REQ-007 SHALL have port redirect, input, 1 bit, the taken branch or jump from the pipeline's PC-select logic.
REQ-008 SHALL have port redirect_pc, input, 32 bits, the target address (BrA or RAA); sampled only when redirect is high.
REQ-009 SHALL have port imem_req, output, 1 bit, the instruction-memory request.
REQ-010 SHALL have port imem_addr, output, 32 bits, the word address of the request.
REQ-011 SHALL have port imem_ack, input, 1 bit, the memory completion; imem_rdata is valid in the same cycle.
REQ-012 SHALL have port imem_rdata, input, 32 bits, the fetched instruction word.
REQ-013 SHALL have port if_valid, output, 1 bit, indicating that the head entry is valid.
REQ-014 SHALL have port if_ir, output, 32 bits, the instruction delivered to decode (IR).
REQ-015 SHALL have port if_pc, output, 32 bits, the PC of if_ir, used by decode for JML.

Function
REQ-016 SHALL implement a request FSM with three states: IDLE (imem_req=0), WAIT (imem_req=1), DISCARD (imem_req=1, response dropped).
REQ-017 SHALL hold imem_addr and imem_req stable while imem_req=1 and imem_ack=0; at most one request SHALL be outstanding.
REQ-018 SHALL, on ack in WAIT, push {imem_rdata, imem_addr} into the buffer and increment the fetch PC by 1 (32-bit wrap, 32'hFFFF_FFFF to 0).
REQ-019 SHALL transition, on any edge where no request remains pending, to WAIT with the new address if (occupancy after this edge's push/pop) < DEPTH, else to IDLE; back-to-back requests SHALL sustain one fetch per cycle.
REQ-020 SHALL ensure the buffer never overflows and that a push and a pop in the same cycle are both honoured.
REQ-021 SHALL pop the head on an edge where if_valid=1 and stall=0.
REQ-022 SHALL drive if_valid=0, if_ir=NOP and if_pc=last popped PC while the buffer is empty.
REQ-023 SHALL, on redirect=1, set the fetch PC to redirect_pc, flush the buffer per REQ-031/032, and ignore stall in that cycle.
REQ-024 SHALL, on redirect in WAIT without ack, move to DISCARD; in DISCARD the ack completes the request, the data is dropped, and the FSM then requests redirect_pc.
REQ-025 SHALL, on redirect coinciding with ack, drop the acked word and request redirect_pc on the next cycle.
REQ-026 SHALL, on redirect in IDLE, go to WAIT at redirect_pc on the next cycle.
REQ-027 SHALL give the latest-cycle redirect priority when a redirect arrives in DISCARD.

Reset
REQ-028 SHALL, while rst=1 (asynchronously), set state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch PC=RESET_PC, buffer empty, if_valid=0, if_ir=NOP, if_pc=0.
REQ-029 SHALL assert imem_req with imem_addr=RESET_PC on the first rising edge after rst falls.
REQ-030 SHALL abandon any outstanding request on rst assertion mid-operation and ignore a late ack.

Configuration
REQ-031 SHALL, when macro FETCH_SQUASH_EN is defined, flush all buffer entries on redirect, so that the cycle after redirect shows if_valid=0, if_ir=NOP.
REQ-032 SHALL, when FETCH_SQUASH_EN is undefined, retain the head entry on redirect (delay slot) unless it is popped in that cycle, and flush all other entries.

Verification
REQ-033 SHALL cover reset release with ack tied high: imem_addr sequence 0,1,2,3; if_ir equals mem[0..3] one cycle after each ack; if_valid continuous.
REQ-034 SHALL cover stall held 5 cycles with DEPTH=2: at most 2 entries are buffered, imem_req=0, and if_ir holds mem[k]; after release, order is preserved with no loss or duplication.
REQ-035 SHALL cover redirect to 32'h40 while WAIT with ack delayed 3 cycles: the ack data is dropped, the next imem_addr is 32'h40, and if_ir equals mem[0x40].
REQ-036 SHALL cover redirect coinciding with ack (imem_addr=5, redirect_pc=32'h10): mem[5] is never delivered and the next request is 32'h10.
REQ-037 SHALL cover redirect with head = mem[7]: with FETCH_SQUASH_EN, if_ir=NOP for the next cycle; without it, mem[7] is delivered and then mem[target].
REQ-038 SHALL cover fetch across 32'hFFFF_FFFF: the next imem_addr is 32'h0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit and instruction memory.
// Latency: n/a (wires only); one request outstanding at a time.
// Backpressure: memory stretches a request by holding imem_ack low; req/addr stay stable until ack.
// Ports:
//   imem_req   : fetch unit requests a word
//   imem_addr  : word address of the request
//   imem_ack   : memory completion, imem_rdata valid in the same cycle
//   imem_rdata : fetched instruction word
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requester feeding a small instruction buffer to decode.
// Latency: acked word is visible on if_ir the cycle after imem_ack; one fetch per cycle when ack is continuous.
// Backpressure: stall holds the head; requests stop while the buffer would be full; redirect flushes.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   imem (fetch_unit_if)      : instruction-memory request bus (master side)
//   stall                     : decode hold, head not consumed while high
//   redirect, redirect_pc     : taken branch/jump and its target word address
//   if_valid, if_ir, if_pc    : head entry to decode; NOP and last consumed PC when empty
// Configuration macro FETCH_SQUASH_EN: when defined, a redirect flushes every buffered entry;
// when undefined, an unconsumed head entry survives the redirect as a delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         if_valid,
  output logic [31:0]  if_ir,
  output logic [31:0]  if_pc
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef logic [PW:0]   cnt_t;
  typedef logic [PW-1:0] ptr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  generate
    if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
      $error("fetch_unit: DEPTH must be 2 or 4");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [31:0] fetch_pc, fetch_pc_d;  // address of the word being / to be fetched
  logic [31:0] addr_q, addr_d;        // address presented on the bus
  logic [31:0] last_pc;               // PC of the most recently consumed entry
  cnt_t        count, count_d;
  ptr_t        rd_ptr, rd_ptr_d;
  ptr_t        wr_ptr, wr_ptr_d;

  logic [31:0] buf_ir [DEPTH];
  logic [31:0] buf_pc [DEPTH];

  logic push;
  logic pop;
  logic busy_after;

  // Stall only decides whether decode consumes the head; a redirect is
  // honoured regardless of stall.
  assign pop  = (count != '0) && !stall;
  // Acked data is kept only in WAIT; a redirect in the same cycle drops it.
  assign push = (state_q == S_WAIT) && imem.imem_ack && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc;
    addr_d     = addr_q;
    count_d    = count;
    rd_ptr_d   = pop ? ptr_t'(rd_ptr + 1'b1) : rd_ptr;
    wr_ptr_d   = push ? ptr_t'(wr_ptr + 1'b1) : wr_ptr;
    busy_after = 1'b0;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
`ifdef FETCH_SQUASH_EN
      count_d = '0;
`else
      // Delay slot: an unconsumed head survives, everything behind it goes.
      count_d = ((count != '0) && !pop) ? cnt_t'(1) : cnt_t'(0);
`endif
      wr_ptr_d = ptr_t'(rd_ptr_d + count_d[PW-1:0]);
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc + 32'd1;
      end
      count_d = count + cnt_t'(push) - cnt_t'(pop);
    end

    // A request is still open after this edge if one is on the bus and not acked.
    busy_after = (state_q != S_IDLE) && !imem.imem_ack;

    if (busy_after) begin
      // Address must stay put until ack; a redirect turns the open request into
      // one whose data will be thrown away. In DISCARD the latest target simply
      // overwrites fetch_pc.
      state_d = (state_q == S_WAIT && redirect) ? S_DISCARD : state_q;
    end else begin
      // Request only when the word can land without overflowing; since the
      // buffer never grows while a request is open, this bounds occupancy.
      addr_d  = fetch_pc_d;
      state_d = (count_d < cnt_t'(DEPTH)) ? S_WAIT : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      last_pc  <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= fetch_pc_d;
      addr_q   <= addr_d;
      count    <= count_d;
      rd_ptr   <= rd_ptr_d;
      wr_ptr   <= wr_ptr_d;
      if (pop) begin
        last_pc <= buf_pc[rd_ptr];
      end
    end
  end

  // Buffer storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_ir[wr_ptr] <= imem.imem_rdata;
      buf_pc[wr_ptr] <= addr_q;
    end
  end

  assign imem.imem_req  = (state_q != S_IDLE);
  assign imem.imem_addr = addr_q;

  assign if_valid = (count != '0);
  assign if_ir    = if_valid ? buf_ir[rd_ptr] : NOP;
  assign if_pc    = if_valid ? buf_pc[rd_ptr] : last_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, streaming, stall, redirect cases, address wrap.
// Latency: n/a. Backpressure: bench drives imem_ack and stall directly.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        ack_drv;

  int total = 0;
  int bad   = 0;

  // Instruction memory contents: never equal to NOP, distinct per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC5, a[23:0]};
  endfunction

  fetch_unit_if bus();

  assign bus.imem_ack   = ack_drv;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .NOP      (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_pc       (if_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic ack);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ack_drv = ack;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ack_drv = 1'b0;
    step(); step();
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%08h exp=00000000", bus.imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", if_valid); end
    total++; if (if_ir !== NOP) begin bad++; $display("FAIL reset_ir got=%08h exp=%08h", if_ir, NOP); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%08h exp=00000000", if_pc); end
    rst = 1'b0;
    step();
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h exp=1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%08h exp=00000000", bus.imem_addr); end
  endtask

  task automatic test_back_to_back();
    reset_dut(1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(k)) begin
        bad++; $display("FAIL b2b_addr k=%0d got=%0h/%08h exp=1/%08h", k, bus.imem_req, bus.imem_addr, 32'(k));
      end
      if (k == 0) begin
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0h exp=0", if_valid); end
      end else begin
        total++; if (if_valid !== 1'b1 || if_ir !== mem_word(32'(k - 1)) || if_pc !== 32'(k - 1)) begin
          bad++; $display("FAIL b2b_data k=%0d got=%0h/%08h/%08h exp=1/%08h/%08h",
                          k, if_valid, if_ir, if_pc, mem_word(32'(k - 1)), 32'(k - 1));
        end
      end
    end
  endtask

  task automatic test_stall();
    reset_dut(1'b1);
    repeat (5) step();
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (bus.imem_req !== 1'b0 || if_valid !== 1'b1 || if_ir !== mem_word(32'd3)) begin
        bad++; $display("FAIL stall_hold c=%0d got=%0h/%0h/%08h exp=0/1/%08h",
                        c, bus.imem_req, if_valid, if_ir, mem_word(32'd3));
      end
    end
    stall = 1'b0;
    for (int j = 4; j < 7; j++) begin
      step();
      total++; if (if_valid !== 1'b1 || if_ir !== mem_word(32'(j)) || if_pc !== 32'(j)) begin
        bad++; $display("FAIL stall_order j=%0d got=%0h/%08h/%08h exp=1/%08h/%08h",
                        j, if_valid, if_ir, if_pc, mem_word(32'(j)), 32'(j));
      end
      if (j == 4) begin
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd5) begin
          bad++; $display("FAIL stall_resume got=%0h/%08h exp=1/00000005", bus.imem_req, bus.imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    reset_dut(1'b0);
    step(); step();
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL wait_hold got=%0h/%08h exp=1/00000000", bus.imem_req, bus.imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
        bad++; $display("FAIL discard_hold c=%0d got=%0h/%08h exp=1/00000000", c, bus.imem_req, bus.imem_addr);
      end
      if (c < 2) step();
    end
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || if_valid !== 1'b0) begin
      bad++; $display("FAIL discard_drop got=%0h/%08h/%0h exp=1/00000040/0", bus.imem_req, bus.imem_addr, if_valid);
    end
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    total++; if (if_valid !== 1'b1 || if_ir !== mem_word(32'h40) || if_pc !== 32'h40) begin
      bad++; $display("FAIL discard_target got=%0h/%08h/%08h exp=1/%08h/00000040", if_valid, if_ir, if_pc, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_ack();
    reset_dut(1'b1);
    repeat (6) step();
    total++; if (bus.imem_addr !== 32'd5 || if_ir !== mem_word(32'd4)) begin
      bad++; $display("FAIL rack_setup got=%08h/%08h exp=00000005/%08h", bus.imem_addr, if_ir, mem_word(32'd4));
    end
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
      bad++; $display("FAIL rack_addr got=%0h/%08h exp=1/00000010", bus.imem_req, bus.imem_addr);
    end
    total++; if (if_valid !== 1'b0 || if_ir !== NOP || if_pc !== 32'd4) begin
      bad++; $display("FAIL rack_empty got=%0h/%08h/%08h exp=0/%08h/00000004", if_valid, if_ir, if_pc, NOP);
    end
    step();
    total++; if (if_valid !== 1'b1 || if_ir !== mem_word(32'h10) || if_pc !== 32'h10) begin
      bad++; $display("FAIL rack_target got=%0h/%08h/%08h exp=1/%08h/00000010", if_valid, if_ir, if_pc, mem_word(32'h10));
    end
  endtask

  task automatic test_delay_slot();
    reset_dut(1'b1);
    repeat (9) step();
    total++; if (if_ir !== mem_word(32'd7)) begin
      bad++; $display("FAIL slot_setup got=%08h exp=%08h", if_ir, mem_word(32'd7));
    end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    step();
    stall = 1'b0; redirect = 1'b0;
`ifdef FETCH_SQUASH_EN
    total++; if (if_valid !== 1'b0 || if_ir !== NOP) begin
      bad++; $display("FAIL slot_squash got=%0h/%08h exp=0/%08h", if_valid, if_ir, NOP);
    end
`else
    total++; if (if_valid !== 1'b1 || if_ir !== mem_word(32'd7) || if_pc !== 32'd7) begin
      bad++; $display("FAIL slot_keep got=%0h/%08h/%08h exp=1/%08h/00000007", if_valid, if_ir, if_pc, mem_word(32'd7));
    end
`endif
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
      bad++; $display("FAIL slot_addr got=%0h/%08h exp=1/00000020", bus.imem_req, bus.imem_addr);
    end
    step();
    total++; if (if_valid !== 1'b1 || if_ir !== mem_word(32'h20) || if_pc !== 32'h20) begin
      bad++; $display("FAIL slot_target got=%0h/%08h/%08h exp=1/%08h/00000020", if_valid, if_ir, if_pc, mem_word(32'h20));
    end
  endtask

  task automatic test_wrap();
    reset_dut(1'b0);
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0; ack_drv = 1'b1;
    step();
    total++; if (bus.imem_addr !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_top got=%08h exp=ffffffff", bus.imem_addr);
    end
    step();
    total++; if (bus.imem_addr !== 32'h0 || if_ir !== mem_word(32'hFFFF_FFFF) || if_pc !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_next got=%08h/%08h/%08h exp=00000000/%08h/ffffffff",
                      bus.imem_addr, if_ir, if_pc, mem_word(32'hFFFF_FFFF));
    end
    step();
    total++; if (if_ir !== mem_word(32'h0) || if_pc !== 32'h0) begin
      bad++; $display("FAIL wrap_zero got=%08h/%08h exp=%08h/00000000", if_ir, if_pc, mem_word(32'h0));
    end
    ack_drv = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_dut(1'b0);
    step();
    stall = 1'b1; ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    step();
    total++; if (bus.imem_addr !== 32'd1 || if_valid !== 1'b1 || if_ir !== mem_word(32'd0)) begin
      bad++; $display("FAIL mid_setup got=%08h/%0h/%08h exp=00000001/1/%08h", bus.imem_addr, if_valid, if_ir, mem_word(32'd0));
    end
    rst = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL mid_async got=%0h/%08h exp=0/00000000", bus.imem_req, bus.imem_addr);
    end
    total++; if (if_valid !== 1'b0 || if_ir !== NOP || if_pc !== 32'h0) begin
      bad++; $display("FAIL mid_flush got=%0h/%08h/%08h exp=0/%08h/00000000", if_valid, if_ir, if_pc, NOP);
    end
    stall = 1'b0; ack_drv = 1'b1;
    step();
    rst = 1'b0;
    step();
    ack_drv = 1'b0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL mid_late_ack got=%0h/%08h/%0h exp=1/00000000/0", bus.imem_req, bus.imem_addr, if_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_delay_slot();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
